// File: rtl/pattern_loader.sv
// Pattern loader: stages a byte-serial pattern, right-justifies it and commits it atomically to the comparator.
// Optional build macro PATTERN_LOADER_CASE_FOLD_EN stores accepted uppercase ASCII bytes as lowercase.
module pattern_loader (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             load_start,
    input  logic             byte_valid,
    input  logic [7:0]       byte_in,
    input  logic             load_done,
    output logic             byte_ready,
    output logic [0:16][7:0] string_out,
    output logic [4:0]       strlen_out,
    output logic             string_valid,
    output logic             clear_out,
    output logic             load_error,
    output logic             busy
);
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_COMMIT = 2'd2,
        S_ERROR  = 2'd3
    } state_t;

    localparam logic [4:0] MAX_LEN = 5'd17;

    state_t           state_q;
    logic [0:16][7:0] staging_q;
    logic [4:0]       count_q;
    logic [0:16][7:0] string_q;
    logic [4:0]       strlen_q;
    logic             valid_q;
    logic             clear_q;
    logic             error_q;
    logic             busy_q;
    logic             ready_q;

    logic [7:0]       byte_stored;
    logic [0:16][7:0] staging_d;
    logic [4:0]       count_d;
    logic             overflow;
    logic             empty_done;

`ifdef PATTERN_LOADER_CASE_FOLD_EN
    assign byte_stored = ((byte_in >= 8'h41) && (byte_in <= 8'h5A)) ? (byte_in | 8'h20) : byte_in;
`else
    assign byte_stored = byte_in;
`endif

    // Staging view including this cycle's byte, so a same-cycle load_done commits it too.
    always_comb begin
        staging_d = staging_q;
        count_d   = count_q;
        if (byte_valid) begin
            staging_d = {staging_q[1:16], byte_stored};
            count_d   = count_q + 5'd1;
        end
    end

    assign overflow   = byte_valid && (count_q == MAX_LEN);
    assign empty_done = load_done && !byte_valid && (count_q == 5'd0);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q   <= S_IDLE;
            staging_q <= '0;
            count_q   <= '0;
            string_q  <= '0;
            strlen_q  <= '0;
            valid_q   <= 1'b0;
            clear_q   <= 1'b0;
            error_q   <= 1'b0;
            busy_q    <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            clear_q <= 1'b0;
            case (state_q)
                S_IDLE, S_ERROR: begin
                    if (load_start) begin
                        state_q   <= S_LOAD;
                        staging_q <= '0;
                        count_q   <= '0;
                        error_q   <= 1'b0;
                        busy_q    <= 1'b1;
                        ready_q   <= 1'b1;
                    end
                end
                S_LOAD: begin
                    if (load_start) begin
                        staging_q <= '0;
                        count_q   <= '0;
                    end else if (overflow || empty_done) begin
                        // Active pattern is left untouched; only load_start leaves ERROR.
                        state_q <= S_ERROR;
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                        ready_q <= 1'b0;
                    end else begin
                        staging_q <= staging_d;
                        count_q   <= count_d;
                        if (load_done) begin
                            state_q  <= S_COMMIT;
                            string_q <= staging_d;
                            strlen_q <= count_d;
                            valid_q  <= 1'b1;
                            clear_q  <= 1'b1;
                            ready_q  <= 1'b0;
                        end
                    end
                end
                S_COMMIT: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign byte_ready   = ready_q;
    assign string_out   = string_q;
    assign strlen_out   = strlen_q;
    assign string_valid = valid_q;
    assign clear_out    = clear_q;
    assign load_error   = error_q;
    assign busy         = busy_q;

endmodule
